// File: rtl/layer_chain_pkg.sv
// Shared definitions for the conv -> max-pool chain sequencer.
//   - lc_state_e : sequencer state encoding
//   - *_DEF      : default geometry and index width
//   - xfer_count : number of activations moved between the two layers
package layer_chain_pkg;

   localparam int unsigned IDX_W_DEF  = 16;
   localparam int unsigned NUM_CH_DEF = 16;
   localparam int unsigned DIM_DEF    = 26;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_L1_RUN,
      ST_XFER,
      ST_DRAIN,
      ST_L2_RUN,
      ST_FINISH,
      ST_ERR
   } lc_state_e;

   // Activations per run: every channel holds a DIM x DIM plane.
   function automatic int unsigned xfer_count(input int unsigned num_ch,
                                              input int unsigned dim);
      return num_ch * dim * dim;
   endfunction

endpackage

// File: rtl/idx3_counter.sv
// Three-dimensional wrap counter (ch, row, col), col fastest.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset
//   clear_i           : return to (0,0,0); has priority over inc_i
//   inc_i             : advance one position
//   ch_o/row_o/col_o  : current position, zero-extended to IDX_W
//   last_o            : position is (NUM_CH-1, DIM-1, DIM-1)
module idx3_counter #(
   parameter int unsigned NUM_CH = 16,
   parameter int unsigned DIM    = 26,
   parameter int unsigned IDX_W  = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [IDX_W-1:0] ch_o,
   output logic [IDX_W-1:0] row_o,
   output logic [IDX_W-1:0] col_o,
   output logic             last_o
);

   localparam logic [IDX_W-1:0] DIM_M1 = IDX_W'(DIM - 1);
   localparam logic [IDX_W-1:0] CH_M1  = IDX_W'(NUM_CH - 1);

   logic [IDX_W-1:0] ch_q, ch_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_q, col_d;
   logic             col_wrap, row_wrap;

   assign col_wrap = (col_q == DIM_M1);
   assign row_wrap = (row_q == DIM_M1);
   assign last_o   = col_wrap && row_wrap && (ch_q == CH_M1);

   always_comb begin
      ch_d  = ch_q;
      row_d = row_q;
      col_d = col_q;
      if (clear_i) begin
         ch_d  = '0;
         row_d = '0;
         col_d = '0;
      end else if (inc_i) begin
         if (col_wrap) begin
            col_d = '0;
            if (row_wrap) begin
               row_d = '0;
               ch_d  = last_o ? '0 : ch_q + 1'b1;
            end else begin
               row_d = row_q + 1'b1;
            end
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ch_q  <= '0;
         row_q <= '0;
         col_q <= '0;
      end else begin
         ch_q  <= ch_d;
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign ch_o  = ch_q;
   assign row_o = row_q;
   assign col_o = col_q;

endmodule

// File: rtl/layer_chain_ctrl.sv
// Sequencer for the conv -> max-pool layer chain.
// A run starts the conv layer, waits for its output_valid, copies every
// activation from the conv output memory into the pool input memory, then
// starts the pool layer and pulses done. A per-layer watchdog parks the
// sequencer in an error state if a layer never reports completion.
// Ports:
//   clk, reset (async, active-low)
//   start                  : run request (level, honoured in IDLE/ERR only)
//   busy / done / error    : run in progress / completion pulse / watchdog flag
//   l1_start, l1_done      : conv layer start pulse and output_valid
//   rd_ch/rd_row/rd_col    : conv output-memory read index
//   wr_en, wr_ch/row/col   : pool input-memory write strobe and index
//   l2_start, l2_done      : pool layer start pulse and output_valid
module layer_chain_ctrl
   import layer_chain_pkg::*;
#(
   parameter int unsigned NUM_CH       = NUM_CH_DEF,
   parameter int unsigned DIM          = DIM_DEF,
   parameter int unsigned IDX_W        = IDX_W_DEF,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned TIMEOUT      = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic             l1_start,
   input  logic             l1_done,
   output logic [IDX_W-1:0] rd_ch,
   output logic [IDX_W-1:0] rd_row,
   output logic [IDX_W-1:0] rd_col,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_ch,
   output logic [IDX_W-1:0] wr_row,
   output logic [IDX_W-1:0] wr_col,
   output logic             l2_start,
   input  logic             l2_done
);

   localparam logic [15:0] DRAIN_LAST = 16'(READ_LATENCY - 1);
   localparam logic [31:0] WD_LAST    = 32'(TIMEOUT - 1);

   lc_state_e   state_q, state_d;
   logic        first_q, first_d;   // first cycle of a layer-run state
   logic [31:0] wd_q, wd_d;
   logic [15:0] dcnt_q, dcnt_d;
   logic        cnt_clr, cnt_inc, cnt_last;
   logic        wd_hit;

   // Read-index generator
   idx3_counter #(
      .NUM_CH (NUM_CH),
      .DIM    (DIM),
      .IDX_W  (IDX_W)
   ) u_rd_idx (
      .clk_i   (clk),
      .rst_ni  (reset),
      .clear_i (cnt_clr),
      .inc_i   (cnt_inc),
      .ch_o    (rd_ch),
      .row_o   (rd_row),
      .col_o   (rd_col),
      .last_o  (cnt_last)
   );

   // Watchdog compares the cycle about to end; a zero limit disables it.
   assign wd_hit = (TIMEOUT != 0) && (wd_q == WD_LAST);

   always_comb begin
      state_d = state_q;
      first_d = 1'b0;
      wd_d    = wd_q;
      dcnt_d  = dcnt_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (start) state_d = ST_L1_RUN;
         end
         ST_L1_RUN: begin
            cnt_clr = 1'b1;
            if (wd_q != '1) wd_d = wd_q + 32'd1;
            // Completion is checked first so a coincident timeout loses.
            if (l1_done)     state_d = ST_XFER;
            else if (wd_hit) state_d = ST_ERR;
         end
         ST_XFER: begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
               state_d = ST_DRAIN;
               dcnt_d  = '0;
            end
         end
         ST_DRAIN: begin
            dcnt_d = dcnt_q + 16'd1;
            if (dcnt_q == DRAIN_LAST) state_d = ST_L2_RUN;
         end
         ST_L2_RUN: begin
            if (wd_q != '1) wd_d = wd_q + 32'd1;
            if (l2_done)     state_d = ST_FINISH;
            else if (wd_hit) state_d = ST_ERR;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Entering a layer run: arm the start pulse and restart the watchdog.
      if ((state_d != state_q) &&
          ((state_d == ST_L1_RUN) || (state_d == ST_L2_RUN))) begin
         first_d = 1'b1;
         wd_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         first_q <= 1'b0;
         wd_q    <= '0;
         dcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
         wd_q    <= wd_d;
         dcnt_q  <= dcnt_d;
      end
   end

   // Read -> write delay line: the write strobe and index trail the read
   // by exactly READ_LATENCY cycles. Cleared on reset so an aborted
   // transfer issues no further writes.
   logic                 vld_q [READ_LATENCY];
   logic [3*IDX_W-1:0]   idx_q [READ_LATENCY];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            vld_q[i] <= 1'b0;
            idx_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= (state_q == ST_XFER);
         idx_q[0] <= {rd_ch, rd_row, rd_col};
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            vld_q[i] <= vld_q[i-1];
            idx_q[i] <= idx_q[i-1];
         end
      end
   end

   assign wr_en                    = vld_q[READ_LATENCY-1];
   assign {wr_ch, wr_row, wr_col}  = idx_q[READ_LATENCY-1];

   assign busy     = (state_q == ST_L1_RUN) || (state_q == ST_XFER)  ||
                     (state_q == ST_DRAIN)  || (state_q == ST_L2_RUN) ||
                     (state_q == ST_FINISH);
   assign done     = (state_q == ST_FINISH);
   assign error    = (state_q == ST_ERR);
   assign l1_start = (state_q == ST_L1_RUN) && first_q;
   assign l2_start = (state_q == ST_L2_RUN) && first_q;

endmodule

// File: tb/tb_layer_chain_ctrl.sv
// Directed bench for layer_chain_ctrl with NUM_CH=2, DIM=3.
// Instance 0: READ_LATENCY=1, no watchdog. Instance 1: READ_LATENCY=3.
// Instance 2: READ_LATENCY=1, TIMEOUT=10.
module tb_layer_chain_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [2:0]  start, l1d, l2d;
   logic [2:0]  busy, done, error, l1s, l2s, wr_en;
   logic [15:0] rd_ch [3];
   logic [15:0] rd_row[3];
   logic [15:0] rd_col[3];
   logic [15:0] wr_ch [3];
   logic [15:0] wr_row[3];
   logic [15:0] wr_col[3];

   int wr_cnt  [3] = '{0, 0, 0};
   int done_cnt[3] = '{0, 0, 0};
   int n_cmp = 0;
   int n_bad = 0;
   int base, dbase;

   layer_chain_ctrl #(.NUM_CH(2), .DIM(3), .IDX_W(16), .READ_LATENCY(1), .TIMEOUT(0)) u_a (
      .clk(clk), .reset(rst_n), .start(start[0]), .busy(busy[0]), .done(done[0]),
      .error(error[0]), .l1_start(l1s[0]), .l1_done(l1d[0]),
      .rd_ch(rd_ch[0]), .rd_row(rd_row[0]), .rd_col(rd_col[0]), .wr_en(wr_en[0]),
      .wr_ch(wr_ch[0]), .wr_row(wr_row[0]), .wr_col(wr_col[0]),
      .l2_start(l2s[0]), .l2_done(l2d[0]));

   layer_chain_ctrl #(.NUM_CH(2), .DIM(3), .IDX_W(16), .READ_LATENCY(3), .TIMEOUT(0)) u_b (
      .clk(clk), .reset(rst_n), .start(start[1]), .busy(busy[1]), .done(done[1]),
      .error(error[1]), .l1_start(l1s[1]), .l1_done(l1d[1]),
      .rd_ch(rd_ch[1]), .rd_row(rd_row[1]), .rd_col(rd_col[1]), .wr_en(wr_en[1]),
      .wr_ch(wr_ch[1]), .wr_row(wr_row[1]), .wr_col(wr_col[1]),
      .l2_start(l2s[1]), .l2_done(l2d[1]));

   layer_chain_ctrl #(.NUM_CH(2), .DIM(3), .IDX_W(16), .READ_LATENCY(1), .TIMEOUT(10)) u_c (
      .clk(clk), .reset(rst_n), .start(start[2]), .busy(busy[2]), .done(done[2]),
      .error(error[2]), .l1_start(l1s[2]), .l1_done(l1d[2]),
      .rd_ch(rd_ch[2]), .rd_row(rd_row[2]), .rd_col(rd_col[2]), .wr_en(wr_en[2]),
      .wr_ch(wr_ch[2]), .wr_row(wr_row[2]), .wr_col(wr_col[2]),
      .l2_start(l2s[2]), .l2_done(l2d[2]));

   // Write and done pulses are tallied mid-cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (wr_en[k]) wr_cnt[k]++;
         if (done[k])  done_cnt[k]++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected (ch,row,col) of the i-th transfer for a 2x3x3 volume.
   function automatic logic [47:0] ex(input int i);
      return {16'(i / 9), 16'((i / 3) % 3), 16'(i % 3)};
   endfunction

   function automatic logic [47:0] rdi(input int k);
      return {rd_ch[k], rd_row[k], rd_col[k]};
   endfunction

   function automatic logic [47:0] wri(input int k);
      return {wr_ch[k], wr_row[k], wr_col[k]};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%012h expected=%012h", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Instance 0 transfer from the first XFER cycle up to the l2_start cycle.
   // With disturb set, start is dropped/re-raised and a stray l2_done is
   // injected mid-transfer.
   task automatic xfer_a(input bit disturb);
      for (int i = 0; i < 18; i++) begin
         if (disturb) begin
            if (i == 4)  start[0] = 1'b0;
            if (i == 6)  start[0] = 1'b1;
            if (i == 8)  l2d[0]   = 1'b1;
            if (i == 9)  l2d[0]   = 1'b0;
            if (i == 10) start[0] = 1'b0;
         end
         chki("xfer_rd", rdi(0), ex(i));
         chk1("xfer_wen", wr_en[0], i >= 1);
         if (i >= 1) chki("xfer_wr", wri(0), ex(i - 1));
         chk1("xfer_busy", busy[0], 1'b1);
         chk1("xfer_l1s", l1s[0], 1'b0);
         tick();
      end
      chk1("drain_wen", wr_en[0], 1'b1);
      chki("drain_wr", wri(0), ex(17));
      chk1("drain_l2s", l2s[0], 1'b0);
      tick();
      chk1("l2s_pulse", l2s[0], 1'b1);
      chk1("l2s_wen", wr_en[0], 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = '0;
      l1d   = '0;
      l2d   = '0;
      tick();
      tick();

      // Reset state of all instances
      for (int k = 0; k < 3; k++) begin
         chki("rst_ctl", 48'({busy[k], done[k], error[k], l1s[k], l2s[k], wr_en[k]}), 48'd0);
         chki("rst_rd", rdi(k), 48'd0);
         chki("rst_wr", wri(k), 48'd0);
      end
      rst_n = 1'b1;
      tick();

      // Nominal run, READ_LATENCY=1
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      chk1("nom_l1s", l1s[0], 1'b1);
      chk1("nom_busy1", busy[0], 1'b1);
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk1("nom_l1s_low", l1s[0], 1'b0);
         chk1("nom_busy_l1", busy[0], 1'b1);
         chk1("nom_wen_l1", wr_en[0], 1'b0);
      end
      l1d[0] = 1'b1;
      tick();
      l1d[0] = 1'b0;
      xfer_a(1'b0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk1("nom_done_early", done[0], 1'b0);
         chk1("nom_busy_l2", busy[0], 1'b1);
      end
      l2d[0] = 1'b1;
      tick();
      l2d[0] = 1'b0;
      chk1("nom_done", done[0], 1'b1);
      chk1("nom_busy_done", busy[0], 1'b1);
      tick();
      chk1("nom_done_end", done[0], 1'b0);
      chk1("nom_busy_end", busy[0], 1'b0);
      chkn("nom_wr_count", wr_cnt[0], 18);
      chkn("nom_done_count", done_cnt[0], 1);

      // READ_LATENCY=3
      start[1] = 1'b1;
      tick();
      start[1] = 1'b0;
      chk1("rl3_l1s", l1s[1], 1'b1);
      l1d[1] = 1'b1;
      tick();
      l1d[1] = 1'b0;
      for (int i = 0; i < 18; i++) begin
         chki("rl3_rd", rdi(1), ex(i));
         chk1("rl3_wen", wr_en[1], i >= 3);
         if (i >= 3) chki("rl3_wr", wri(1), ex(i - 3));
         tick();
      end
      for (int j = 0; j < 3; j++) begin
         chk1("rl3_drain_wen", wr_en[1], 1'b1);
         chki("rl3_drain_wr", wri(1), ex(15 + j));
         chk1("rl3_drain_l2s", l2s[1], 1'b0);
         chk1("rl3_drain_busy", busy[1], 1'b1);
         tick();
      end
      chk1("rl3_l2s", l2s[1], 1'b1);
      chk1("rl3_l2s_wen", wr_en[1], 1'b0);
      l2d[1] = 1'b1;
      tick();
      l2d[1] = 1'b0;
      chk1("rl3_done", done[1], 1'b1);
      tick();
      chk1("rl3_idle", busy[1], 1'b0);
      chkn("rl3_wr_count", wr_cnt[1], 18);

      // Watchdog TIMEOUT=10 on a conv layer that never completes
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      chk1("wd_l1s", l1s[2], 1'b1);
      for (int c = 1; c <= 10; c++) begin
         chk1("wd_busy_run", busy[2], 1'b1);
         chk1("wd_err_run", error[2], 1'b0);
         tick();
      end
      chk1("wd_error", error[2], 1'b1);
      chk1("wd_busy_err", busy[2], 1'b0);
      tick();
      tick();
      chk1("wd_sticky", error[2], 1'b1);
      chkn("wd_no_wr", wr_cnt[2], 0);
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      chk1("wd_clear", error[2], 1'b0);
      chk1("wd_restart_l1s", l1s[2], 1'b1);
      chk1("wd_restart_busy", busy[2], 1'b1);

      // l1_done in the l1_start cycle, then l2_done coinciding with timeout
      l1d[2] = 1'b1;
      tick();
      l1d[2] = 1'b0;
      chki("same_rd0", rdi(2), ex(0));
      tick();
      chki("same_rd1", rdi(2), ex(1));
      repeat (18) tick();
      chk1("coin_l2s", l2s[2], 1'b1);
      for (int c = 2; c <= 10; c++) begin
         tick();
         chk1("coin_busy", busy[2], 1'b1);
         chk1("coin_err_run", error[2], 1'b0);
         chk1("coin_done_early", done[2], 1'b0);
      end
      l2d[2] = 1'b1;
      tick();
      l2d[2] = 1'b0;
      chk1("coin_done", done[2], 1'b1);
      chk1("coin_err", error[2], 1'b0);
      tick();
      chk1("coin_err_after", error[2], 1'b0);
      chk1("coin_idle", busy[2], 1'b0);
      chkn("coin_wr_count", wr_cnt[2], 18);

      // start held and re-pulsed, stray l2_done during XFER
      base = wr_cnt[0];
      start[0] = 1'b1;
      tick();
      chk1("hold_l1s", l1s[0], 1'b1);
      l1d[0] = 1'b1;
      tick();
      l1d[0] = 1'b0;
      xfer_a(1'b1);
      l2d[0] = 1'b1;
      tick();
      l2d[0] = 1'b0;
      chk1("hold_done", done[0], 1'b1);
      tick();
      chk1("hold_idle", busy[0], 1'b0);
      chkn("hold_wr_count", wr_cnt[0] - base, 18);
      chkn("hold_done_count", done_cnt[0], 2);

      // Reset in the middle of a transfer
      base = wr_cnt[0];
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      l1d[0] = 1'b1;
      tick();
      l1d[0] = 1'b0;
      repeat (8) tick();
      chkn("mid_wr_before", wr_cnt[0] - base, 7);
      chk1("mid_wen_before", wr_en[0], 1'b1);
      rst_n = 1'b0;
      #1;
      chki("mid_rst_ctl", 48'({busy[0], done[0], error[0], l1s[0], l2s[0], wr_en[0]}), 48'd0);
      chki("mid_rst_rd", rdi(0), 48'd0);
      chki("mid_rst_wr", wri(0), 48'd0);
      dbase = done_cnt[0];
      tick();
      tick();
      chkn("mid_no_more_wr", wr_cnt[0] - base, 7);
      rst_n = 1'b1;
      tick();
      tick();
      chk1("mid_idle", busy[0], 1'b0);
      chkn("mid_no_done", done_cnt[0], dbase);
      base = wr_cnt[0];
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      l1d[0] = 1'b1;
      tick();
      l1d[0] = 1'b0;
      xfer_a(1'b0);
      l2d[0] = 1'b1;
      tick();
      l2d[0] = 1'b0;
      chk1("post_done", done[0], 1'b1);
      tick();
      chkn("post_wr_count", wr_cnt[0] - base, 18);
      chkn("post_done_count", done_cnt[0], dbase + 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
